// File: rtl/alu_share_arb.sv
// alu_share_arb: one combinational alu shared by two requesters.
//   Round-robin (or fixed-priority) grant, one operand register stage, and a
//   one-entry response buffer with valid/ready backpressure. op_count is a
//   saturating tally of delivered responses.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req{0,1}_valid/_ready       requester handshake
//   req{0,1}_a/_b/_op/_sub      alu operands and operation select
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_id          alu result and issuing requester
//   busy                        controller not idle
//   op_count                    saturating count of response handshakes

// alu: purely combinational.
//   a, b  operands; op selects the function; sub picks sub for add and
//   arithmetic shift for srl; y is the result.
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  op,
    input  logic        sub,
    output logic [31:0] y
);
    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        y = '0;
        case (op)
            3'b000: y = sub ? (a - b) : (a + b);
            3'b001: y = a << shamt;
            3'b010: y = {31'b0, ($signed(a) < $signed(b))};
            3'b011: y = {31'b0, (a < b)};
            3'b100: y = a ^ b;
            3'b101: y = sub ? 32'($signed(a) >>> shamt) : (a >> shamt);
            3'b110: y = a | b;
            3'b111: y = a & b;
            default: y = '0;
        endcase
    end
endmodule

// State table:
//   IDLE | no op in flight, accepting requests
//   EXEC | operands latched, alu result captured at next edge
//   HOLD | response buffered until rsp_ready; may accept on the handshake edge
module alu_share_arb #(
    parameter int RR_EN = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req0_sub,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [2:0]       req1_op,
    input  logic             req1_sub,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        last_grant;
    logic [31:0] opnd_a;
    logic [31:0] opnd_b;
    logic [2:0]  opnd_op;
    logic        opnd_sub;
    logic        opnd_id;

    logic        can_acc;
    logic        grant;
    logic        accept;
    logic        rsp_done;
    logic [31:0] alu_y;

    alu u_alu (
        .a   (opnd_a),
        .b   (opnd_b),
        .op  (opnd_op),
        .sub (opnd_sub),
        .y   (alu_y)
    );

    // rsp_valid is always 1 in HOLD, so rsp_ready alone marks the handshake.
    assign rsp_done = (state == HOLD) && rsp_ready;
    assign can_acc  = (state == IDLE) || rsp_done;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = (RR_EN != 0) ? ~last_grant : 1'b0;
        else if (req1_valid)
            grant = 1'b1;
    end

    assign req0_ready = can_acc && !grant && req0_valid;
    assign req1_ready = can_acc &&  grant && req1_valid;
    assign accept     = req0_ready || req1_ready;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (accept) state_nx = EXEC;
            EXEC: state_nx = HOLD;
            HOLD: if (rsp_done) state_nx = accept ? EXEC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= 1'b1;
            opnd_a     <= '0;
            opnd_b     <= '0;
            opnd_op    <= '0;
            opnd_sub   <= 1'b0;
            opnd_id    <= 1'b0;
        end else if (accept) begin
            last_grant <= grant;
            opnd_a     <= grant ? req1_a   : req0_a;
            opnd_b     <= grant ? req1_b   : req0_b;
            opnd_op    <= grant ? req1_op  : req0_op;
            opnd_sub   <= grant ? req1_sub : req0_sub;
            opnd_id    <= grant;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= 1'b0;
        end else if (state == EXEC) begin
            rsp_valid  <= 1'b1;
            rsp_result <= alu_y;
            rsp_id     <= opnd_id;
        end else if (rsp_done) begin
            rsp_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            op_count <= '0;
        else if (rsp_done && (op_count != {CNT_W{1'b1}}))
            op_count <= op_count + CNT_W'(1);
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb. Three instances share one set of inputs:
//   m_*  round-robin, 16-bit counter
//   f_*  fixed priority (req0 always wins ties)
//   s_*  round-robin, 2-bit counter to reach saturation quickly
module tb_alu_share_arb;
    logic        clk;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]  req0_op, req1_op;
    logic        req0_sub, req1_sub;
    logic        rsp_ready;

    logic        m_req0_ready, m_req1_ready, m_rsp_valid, m_rsp_id, m_busy;
    logic [31:0] m_rsp_result;
    logic [15:0] m_op_count;
    logic        f_req0_ready, f_req1_ready, f_rsp_valid, f_rsp_id, f_busy;
    logic [31:0] f_rsp_result;
    logic [15:0] f_op_count;
    logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_busy;
    logic [31:0] s_rsp_result;
    logic [1:0]  s_op_count;

    int total = 0;
    int bad   = 0;

    alu_share_arb #(.RR_EN(1), .CNT_W(16)) dut_m (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(m_req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(m_req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op), .req1_sub(req1_sub),
        .rsp_valid(m_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(m_rsp_result),
        .rsp_id(m_rsp_id), .busy(m_busy), .op_count(m_op_count)
    );

    alu_share_arb #(.RR_EN(0), .CNT_W(16)) dut_f (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op), .req1_sub(req1_sub),
        .rsp_valid(f_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(f_rsp_result),
        .rsp_id(f_rsp_id), .busy(f_busy), .op_count(f_op_count)
    );

    alu_share_arb #(.RR_EN(1), .CNT_W(2)) dut_s (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_op(req0_op), .req0_sub(req0_sub),
        .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_op(req1_op), .req1_sub(req1_sub),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(s_rsp_result),
        .rsp_id(s_rsp_id), .busy(s_busy), .op_count(s_op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns 3 time units after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #3;
    endtask

    // Issue one op on requester 0 with rsp_ready already set; returns in HOLD.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic sub);
        req0_a = a; req0_b = b; req0_op = op; req0_sub = sub;
        req0_valid = 1'b1;
        cycle();
        req0_valid = 1'b0;
        cycle();
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0; req0_sub = 0;
        req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0; req1_sub = 0;
        rsp_ready = 0;
        cycle();
        cycle();

        chk("rst_valid",  m_rsp_valid,  0);
        chk("rst_result", m_rsp_result, 0);
        chk("rst_id",     m_rsp_id,     0);
        chk("rst_busy",   m_busy,       0);
        chk("rst_count",  m_op_count,   0);
        rst = 1'b0;

        // 5 - 3 via sub
        req0_a = 5; req0_b = 3; req0_op = 3'b000; req0_sub = 1'b1;
        req0_valid = 1'b1; rsp_ready = 1'b1;
        #1;
        chk("t1_r0_ready", m_req0_ready, 1);
        chk("t1_r1_ready", m_req1_ready, 0);
        cycle();
        req0_valid = 1'b0;
        chk("t1_exec_valid", m_rsp_valid, 0);
        chk("t1_exec_busy",  m_busy,      1);
        cycle();
        chk("t1_valid",  m_rsp_valid,  1);
        chk("t1_result", m_rsp_result, 32'd2);
        chk("t1_id",     m_rsp_id,     0);
        chk("t1_count0", m_op_count,   0);
        cycle();
        chk("t1_count1", m_op_count,   1);
        chk("t1_idle_valid", m_rsp_valid, 0);
        chk("t1_idle_busy",  m_busy,      0);

        // Both requesters from reset: sll 1<<1 and slt -1<0
        rst = 1'b1; #1; rst = 1'b0;
        req0_a = 1; req0_b = 33; req0_op = 3'b001; req0_sub = 0;
        req1_a = 32'hFFFF_FFFF; req1_b = 0; req1_op = 3'b010; req1_sub = 0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("t2_m_r0_ready", m_req0_ready, 1);
        chk("t2_m_r1_ready", m_req1_ready, 0);
        chk("t2_f_r0_ready", f_req0_ready, 1);
        cycle();
        cycle();
        chk("t2_m_res0", m_rsp_result, 32'd2);
        chk("t2_m_id0",  m_rsp_id,     0);
        chk("t2_f_res0", f_rsp_result, 32'd2);
        chk("t2_m_r1_ready_hold", m_req1_ready, 1);
        chk("t2_m_r0_ready_hold", m_req0_ready, 0);
        chk("t2_f_r0_ready_hold", f_req0_ready, 1);
        chk("t2_f_r1_ready_hold", f_req1_ready, 0);
        cycle();
        cycle();
        chk("t2_m_res1", m_rsp_result, 32'd1);
        chk("t2_m_id1",  m_rsp_id,     1);
        chk("t2_f_res1", f_rsp_result, 32'd2);
        chk("t2_f_id1",  f_rsp_id,     0);
        chk("t2_m_r0_next", m_req0_ready, 1);
        req0_valid = 1'b0; req1_valid = 1'b0;
        cycle();
        chk("t2_m_count", m_op_count, 2);
        chk("t2_m_busy",  m_busy,     0);
        chk("t2_s_count", s_op_count, 2);

        // Backpressure: xor on req0, or on req1
        rsp_ready = 1'b0;
        req0_a = 32'h0000_F0F0; req0_b = 32'h0000_0FF0; req0_op = 3'b100; req0_sub = 0;
        req1_a = 32'h12; req1_b = 32'h21; req1_op = 3'b110; req1_sub = 0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("t3_m_r0_ready", m_req0_ready, 1);
        cycle();
        cycle();
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_valid",  m_rsp_valid,  1);
            chk("t3_stall_result", m_rsp_result, 32'h0000_FF00);
            chk("t3_stall_id",     m_rsp_id,     0);
            chk("t3_stall_r0",     m_req0_ready, 0);
            chk("t3_stall_r1",     m_req1_ready, 0);
            chk("t3_stall_count",  m_op_count,   2);
            cycle();
        end
        rsp_ready = 1'b1;
        #1;
        chk("t3_release_r1", m_req1_ready, 1);
        cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("t3_exec_valid", m_rsp_valid, 0);
        chk("t3_exec_busy",  m_busy,      1);
        chk("t3_count3",     m_op_count,  3);
        cycle();
        chk("t3_res2", m_rsp_result, 32'h33);
        chk("t3_id2",  m_rsp_id,     1);
        cycle();
        chk("t3_count4", m_op_count, 4);
        chk("t3_s_sat",  s_op_count, 3);

        // Shift right arithmetic vs logical
        do_op(32'h8000_0000, 32'd4, 3'b101, 1'b1);
        chk("t4_sra", m_rsp_result, 32'hF800_0000);
        cycle();
        do_op(32'h8000_0000, 32'd4, 3'b101, 1'b0);
        chk("t4_srl", m_rsp_result, 32'h0800_0000);
        cycle();
        do_op(32'd1, 32'hFFFF_FFFF, 3'b011, 1'b0);
        chk("t4_sltu", m_rsp_result, 32'd1);
        cycle();
        chk("t4_count", m_op_count, 7);

        // Reset while in EXEC
        req0_a = 1; req0_b = 1; req0_op = 3'b000; req0_sub = 0;
        req0_valid = 1'b1;
        cycle();
        req0_valid = 1'b0;
        chk("t5_busy_pre", m_busy, 1);
        rst = 1'b1;
        #1;
        chk("t5_valid", m_rsp_valid, 0);
        chk("t5_busy",  m_busy,      0);
        chk("t5_count", m_op_count,  0);
        chk("t5_s_count", s_op_count, 0);
        rst = 1'b0;
        cycle();
        chk("t5_no_rsp_a", m_rsp_valid, 0);
        cycle();
        chk("t5_no_rsp_b", m_rsp_valid, 0);

        // Five adds: narrow counter saturates
        for (int i = 0; i < 5; i++) begin
            do_op(32'(i), 32'd10, 3'b000, 1'b0);
            chk("t6_add", m_rsp_result, 32'(i + 10));
            cycle();
        end
        chk("t6_m_count", m_op_count, 5);
        chk("t6_s_count", s_op_count, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
